// File: rtl/i_cache_assoc.sv
// Set-associative read-only instruction cache between fetch and imem.
// Multi-word blocks, 1/2 ways with per-set LRU, fence.i set walk.
module i_cache_assoc #(
  parameter int XLEN       = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int ENTRIES    = 64,
  parameter int WAYS       = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [XLEN-1:0]          i_Addr,
  input  logic                     i_Flush,
  output logic [XLEN-1:0]          o_Data,
  output logic                     o_Stall,
  output logic                     o_DataReq,
  output logic [XLEN-1:0]          o_MemAddr,
  input  logic                     i_MemReady,
  input  logic [BLOCK_SIZE*32-1:0] i_DataBlock,
  output logic                     o_Busy
);

  localparam int M  = $clog2(BLOCK_SIZE);
  localparam int N  = $clog2(ENTRIES);
  localparam int TW = XLEN - M - N - 2;
  localparam int BW = BLOCK_SIZE * 32;
  localparam int MW = (M > 0) ? M : 1;

  localparam logic [N-1:0] LAST = N'(ENTRIES - 1);
  localparam logic [XLEN-1:0] AMASK =
    ~XLEN'((64'd1 << (M + 2)) - 64'd1);

  typedef enum logic [1:0] {
    LOOKUP,
    ALLOCATE,
    FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [ENTRIES-1:0] valid_q [WAYS];
  logic [ENTRIES-1:0] lru_q;
  logic [TW-1:0]      tag_q   [WAYS][ENTRIES];
  logic [BW-1:0]      data_q  [WAYS][ENTRIES];
  logic [N-1:0]       cnt_q;
  logic               pend_q;

  logic [N-1:0]    idx;
  logic [TW-1:0]   tag;
  logic [MW-1:0]   off;
  logic [WAYS-1:0] hit_way;
  logic            hit;
  logic            hit_sel;
  logic            victim;
  logic [BW-1:0]   blk_sel;
  logic [31:0]     word;

  logic fill_en;
  logic lru_we;
  logic lru_val;
  logic flush_clr;
  logic pend_set;

  logic unused_addr;
  assign unused_addr = ^i_Addr[1:0];

  assign idx = i_Addr[M+2 +: N];
  assign tag = i_Addr[XLEN-1 -: TW];

  generate
    if (M > 0) begin : g_off
      assign off = i_Addr[2 +: MW];
    end else begin : g_no_off
      assign off = '0;
    end
  endgenerate

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      hit_way[w] = valid_q[w][idx] &&
                   (tag_q[w][idx] == tag);
    end
  end

  // way 0 wins if both ways ever match
  assign hit     = |hit_way;
  assign hit_sel = (WAYS > 1) && !hit_way[0];

  always_comb begin
    victim = 1'b0;
    if (WAYS > 1 && valid_q[0][idx]) begin
      victim = valid_q[WAYS-1][idx] ?
               lru_q[idx] : 1'b1;
    end
  end

  assign blk_sel   = data_q[hit_sel][idx];
  assign word      = blk_sel[32*off +: 32];
  assign o_MemAddr = i_Addr & AMASK;

  always_comb begin
    state_d   = state_q;
    o_Stall   = 1'b1;
    o_Data    = '0;
    o_DataReq = 1'b0;
    o_Busy    = 1'b0;
    fill_en   = 1'b0;
    lru_we    = 1'b0;
    lru_val   = 1'b0;
    flush_clr = 1'b0;
    pend_set  = 1'b0;
    unique case (state_q)
      LOOKUP: begin
        if (i_Flush) begin
          state_d = FLUSH;
        end else if (hit) begin
          o_Stall = 1'b0;
          o_Data  = XLEN'(word);
          lru_we  = 1'b1;
          lru_val = ~hit_sel;
        end else begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        o_DataReq = 1'b1;
        pend_set  = i_Flush;
        if (i_MemReady) begin
          fill_en = 1'b1;
          state_d = (pend_q || i_Flush) ?
                    FLUSH : LOOKUP;
        end
      end
      FLUSH: begin
        o_Busy    = 1'b1;
        flush_clr = 1'b1;
        if (cnt_q == LAST) state_d = LOOKUP;
      end
      default: state_d = LOOKUP;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= LOOKUP;
      lru_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (pend_set) pend_q <= 1'b1;
      if (lru_we) lru_q[idx] <= lru_val;
      if (fill_en) begin
        valid_q[victim][idx] <= 1'b1;
        lru_q[idx]           <= ~victim;
      end
      if (flush_clr) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w][cnt_q] <= 1'b0;
        end
        lru_q[cnt_q] <= 1'b0;
        cnt_q        <= cnt_q + 1'b1;
        if (cnt_q == LAST) pend_q <= 1'b0;
      end
    end
  end

  // payload arrays need no reset; valid bits gate them
  always_ff @(posedge i_clk) begin
    if (fill_en) begin
      tag_q[victim][idx]  <= tag;
      data_q[victim][idx] <= i_DataBlock;
    end
  end

endmodule
